// File: rtl/execute_stage.sv
// Execute stage of a 5-stage MIPS-style pipeline: ALU, branch/jump resolution and the EX/MEM register.
// Optional iterative MULT/DIV unit with HI/LO registers is enabled by defining EX_MULDIV_EN.
module execute_stage #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_stall_c,
  input  logic [ADDRESS_SIZE-1:0] ID_EX_nextPC,
  input  logic [DATA_SIZE-1:0]    ID_EX_A,
  input  logic [DATA_SIZE-1:0]    ID_EX_B,
  input  logic [15:0]             ID_EX_imm,
  input  logic [4:0]              ID_EX_rs,
  input  logic [4:0]              ID_EX_rt,
  input  logic [4:0]              ID_EX_rd,
  input  logic [5:0]              ID_EX_op,
  input  logic [1:0]              ID_EX_instruc_type,
  output logic [DATA_SIZE-1:0]    EX_MEM_ALUout,
  output logic [DATA_SIZE-1:0]    EX_MEM_B,
  output logic [4:0]              EX_MEM_dest,
  output logic [5:0]              EX_MEM_op,
  output logic [1:0]              EX_MEM_instruc_type,
  output logic                    EX_MEM_regwrite,
  output logic                    EX_MEM_branch_taken,
  output logic [ADDRESS_SIZE-1:0] EX_MEM_target,
  output logic                    ex_stall_c
);

  localparam logic [1:0] TYPE_R = 2'b11;
  localparam logic [1:0] TYPE_I = 2'b10;
  localparam logic [1:0] TYPE_J = 2'b01;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_MFHI = 6'b010000;
  localparam logic [5:0] OP_MFLO = 6'b010010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef EX_MULDIV_EN
  localparam logic [5:0] OP_MULT = 6'b011000;
  localparam logic [5:0] OP_DIV  = 6'b011010;
`endif

  logic [DATA_SIZE-1:0]    sext_imm;
  logic [ADDRESS_SIZE-1:0] br_offset;
  logic [ADDRESS_SIZE-1:0] j_target;
  logic [DATA_SIZE-1:0]    hi_val;
  logic [DATA_SIZE-1:0]    lo_val;
  logic                    load_slot;

  logic [DATA_SIZE-1:0]    dec_alu;
  logic [4:0]              dec_dest;
  logic                    dec_regwrite;
  logic                    dec_taken;
  logic [ADDRESS_SIZE-1:0] dec_target;
`ifdef EX_MULDIV_EN
  logic                    dec_muldiv;
  logic                    dec_is_div;
`endif

  logic [DATA_SIZE-1:0]    alu_out_q, alu_out_d;
  logic [DATA_SIZE-1:0]    b_q, b_d;
  logic [4:0]              dest_q, dest_d;
  logic [5:0]              op_q, op_d;
  logic [1:0]              type_q, type_d;
  logic                    regwrite_q, regwrite_d;
  logic                    taken_q, taken_d;
  logic [ADDRESS_SIZE-1:0] target_q, target_d;

  assign sext_imm  = {{(DATA_SIZE-16){ID_EX_imm[15]}}, ID_EX_imm};
  assign br_offset = {{(ADDRESS_SIZE-18){ID_EX_imm[15]}}, ID_EX_imm, 2'b00};
  assign j_target  = {ID_EX_nextPC[ADDRESS_SIZE-1:28], ID_EX_rs, ID_EX_rt, ID_EX_imm, 2'b00};

  always_comb begin
    dec_alu      = '0;
    dec_dest     = 5'd0;
    dec_regwrite = 1'b0;
    dec_taken    = 1'b0;
    dec_target   = '0;
`ifdef EX_MULDIV_EN
    dec_muldiv   = 1'b0;
    dec_is_div   = 1'b0;
`endif
    case (ID_EX_instruc_type)
      TYPE_R: begin
        dec_dest     = ID_EX_rd;
        dec_regwrite = 1'b1;
        case (ID_EX_op)
          OP_ADD:  dec_alu = ID_EX_A + ID_EX_B;
          OP_SUB:  dec_alu = ID_EX_A - ID_EX_B;
          OP_AND:  dec_alu = ID_EX_A & ID_EX_B;
          OP_OR:   dec_alu = ID_EX_A | ID_EX_B;
          OP_SLT:  dec_alu = DATA_SIZE'($signed(ID_EX_A) < $signed(ID_EX_B));
          OP_MFHI: dec_alu = hi_val;
          OP_MFLO: dec_alu = lo_val;
`ifdef EX_MULDIV_EN
          OP_MULT, OP_DIV: begin
            dec_dest     = 5'd0;
            dec_regwrite = 1'b0;
            dec_muldiv   = 1'b1;
            dec_is_div   = (ID_EX_op == OP_DIV);
          end
`endif
          default: begin
            dec_dest     = 5'd0;
            dec_regwrite = 1'b0;
          end
        endcase
      end
      TYPE_I: begin
        case (ID_EX_op)
          OP_ADDI, OP_LW: begin
            dec_alu      = ID_EX_A + sext_imm;
            dec_dest     = ID_EX_rt;
            dec_regwrite = 1'b1;
          end
          OP_SW:   dec_alu = ID_EX_A + sext_imm;
          OP_BEQ: begin
            dec_taken  = (ID_EX_A == ID_EX_B);
            dec_target = ID_EX_nextPC + br_offset;
          end
          default: ;
        endcase
      end
      TYPE_J: begin
        if (ID_EX_op == OP_J) begin
          dec_taken  = 1'b1;
          dec_target = j_target;
        end
      end
      default: ;
    endcase
  end

  // Slot loads the decoded instruction, a bubble when busy/starting mul-div, or holds under memory stall.
  always_comb begin
    alu_out_d  = alu_out_q;
    b_d        = b_q;
    dest_d     = dest_q;
    op_d       = op_q;
    type_d     = type_q;
    regwrite_d = regwrite_q;
    taken_d    = taken_q;
    target_d   = target_q;
    if (!mem_stall_c) begin
      if (load_slot) begin
        alu_out_d  = dec_alu;
        b_d        = ID_EX_B;
        dest_d     = dec_dest;
        op_d       = ID_EX_op;
        type_d     = ID_EX_instruc_type;
        regwrite_d = dec_regwrite;
        taken_d    = dec_taken;
        target_d   = dec_target;
      end else begin
        alu_out_d  = '0;
        b_d        = '0;
        dest_d     = 5'd0;
        op_d       = 6'd0;
        type_d     = 2'b00;
        regwrite_d = 1'b0;
        taken_d    = 1'b0;
        target_d   = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_out_q  <= '0;
      b_q        <= '0;
      dest_q     <= 5'd0;
      op_q       <= 6'd0;
      type_q     <= 2'b00;
      regwrite_q <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
    end else begin
      alu_out_q  <= alu_out_d;
      b_q        <= b_d;
      dest_q     <= dest_d;
      op_q       <= op_d;
      type_q     <= type_d;
      regwrite_q <= regwrite_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
    end
  end

  assign EX_MEM_ALUout       = alu_out_q;
  assign EX_MEM_B            = b_q;
  assign EX_MEM_dest         = dest_q;
  assign EX_MEM_op           = op_q;
  assign EX_MEM_instruc_type = type_q;
  assign EX_MEM_regwrite     = regwrite_q;
  assign EX_MEM_branch_taken = taken_q;
  assign EX_MEM_target       = target_q;

`ifdef EX_MULDIV_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam int CNT_W = $clog2(DATA_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE - 1);

  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*DATA_SIZE-1:0] acc_q, acc_d;
  logic [DATA_SIZE-1:0]   opnd_q, opnd_d;
  logic                   is_div_q, is_div_d;
  logic [DATA_SIZE-1:0]   hi_q, hi_d;
  logic [DATA_SIZE-1:0]   lo_q, lo_d;

  logic [DATA_SIZE-1:0]   mul_addend;
  logic [DATA_SIZE:0]     mul_sum;
  logic [DATA_SIZE:0]     div_shift;
  logic                   div_fits;
  logic [DATA_SIZE-1:0]   div_diff;
  logic [2*DATA_SIZE-1:0] iter_acc;

  assign hi_val     = hi_q;
  assign lo_val     = lo_q;
  assign load_slot  = (state_q == ST_IDLE) && !dec_muldiv;
  assign ex_stall_c = (state_q == ST_BUSY);

  // acc holds {partial_hi, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_addend = acc_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, acc_q[2*DATA_SIZE-1:DATA_SIZE]} + {1'b0, mul_addend};
    div_shift  = {acc_q[2*DATA_SIZE-1:DATA_SIZE], acc_q[DATA_SIZE-1]};
    div_fits   = (div_shift >= {1'b0, opnd_q});
    div_diff   = div_shift[DATA_SIZE-1:0] - opnd_q;
    if (is_div_q)
      iter_acc = {(div_fits ? div_diff : div_shift[DATA_SIZE-1:0]), acc_q[DATA_SIZE-2:0], div_fits};
    else
      iter_acc = {mul_sum, acc_q[DATA_SIZE-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (!mem_stall_c && dec_muldiv) begin
          state_d  = ST_BUSY;
          cnt_d    = '0;
          is_div_d = dec_is_div;
          if (dec_is_div) begin
            acc_d  = {{DATA_SIZE{1'b0}}, ID_EX_A};
            opnd_d = ID_EX_B;
          end else begin
            acc_d  = {{DATA_SIZE{1'b0}}, ID_EX_B};
            opnd_d = ID_EX_A;
          end
        end
      end
      default: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = iter_acc[2*DATA_SIZE-1:DATA_SIZE];
          lo_d    = iter_acc[DATA_SIZE-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
`else
  assign hi_val     = '0;
  assign lo_val     = '0;
  assign load_slot  = 1'b1;
  assign ex_stall_c = 1'b0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: ALU ops, branches, memory stall and (if EX_MULDIV_EN) MULT/DIV.
module tb_execute_stage;

  logic        clock;
  logic        reset;
  logic        mem_stall_c;
  logic [31:0] ID_EX_nextPC;
  logic [31:0] ID_EX_A;
  logic [31:0] ID_EX_B;
  logic [15:0] ID_EX_imm;
  logic [4:0]  ID_EX_rs;
  logic [4:0]  ID_EX_rt;
  logic [4:0]  ID_EX_rd;
  logic [5:0]  ID_EX_op;
  logic [1:0]  ID_EX_instruc_type;
  logic [31:0] EX_MEM_ALUout;
  logic [31:0] EX_MEM_B;
  logic [4:0]  EX_MEM_dest;
  logic [5:0]  EX_MEM_op;
  logic [1:0]  EX_MEM_instruc_type;
  logic        EX_MEM_regwrite;
  logic        EX_MEM_branch_taken;
  logic [31:0] EX_MEM_target;
  logic        ex_stall_c;

  int total = 0;
  int bad   = 0;

  execute_stage #(.DATA_SIZE(32), .ADDRESS_SIZE(32)) dut (
    .clock               (clock),
    .reset               (reset),
    .mem_stall_c         (mem_stall_c),
    .ID_EX_nextPC        (ID_EX_nextPC),
    .ID_EX_A             (ID_EX_A),
    .ID_EX_B             (ID_EX_B),
    .ID_EX_imm           (ID_EX_imm),
    .ID_EX_rs            (ID_EX_rs),
    .ID_EX_rt            (ID_EX_rt),
    .ID_EX_rd            (ID_EX_rd),
    .ID_EX_op            (ID_EX_op),
    .ID_EX_instruc_type  (ID_EX_instruc_type),
    .EX_MEM_ALUout       (EX_MEM_ALUout),
    .EX_MEM_B            (EX_MEM_B),
    .EX_MEM_dest         (EX_MEM_dest),
    .EX_MEM_op           (EX_MEM_op),
    .EX_MEM_instruc_type (EX_MEM_instruc_type),
    .EX_MEM_regwrite     (EX_MEM_regwrite),
    .EX_MEM_branch_taken (EX_MEM_branch_taken),
    .EX_MEM_target       (EX_MEM_target),
    .ex_stall_c          (ex_stall_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one instruction into ID/EX and advances one clock edge.
  task automatic applyStimulus(input logic [1:0] ty, input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [15:0] imm, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc);
    ID_EX_instruc_type = ty;
    ID_EX_op           = op;
    ID_EX_A            = a;
    ID_EX_B            = b;
    ID_EX_imm          = imm;
    ID_EX_rs           = rs;
    ID_EX_rt           = rt;
    ID_EX_rd           = rd;
    ID_EX_nextPC       = pc;
    step();
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_alu"},   EX_MEM_ALUout, 0);
    checkOutput({tag, "_b"},     EX_MEM_B, 0);
    checkOutput({tag, "_dest"},  EX_MEM_dest, 0);
    checkOutput({tag, "_op"},    EX_MEM_op, 0);
    checkOutput({tag, "_type"},  EX_MEM_instruc_type, 0);
    checkOutput({tag, "_rw"},    EX_MEM_regwrite, 0);
    checkOutput({tag, "_taken"}, EX_MEM_branch_taken, 0);
    checkOutput({tag, "_tgt"},   EX_MEM_target, 0);
    checkOutput({tag, "_stall"}, ex_stall_c, 0);
  endtask

`ifdef EX_MULDIV_EN
  // Issues MULT/DIV, checks the bubble, then counts how many cycles ex_stall_c stays high.
  task automatic runMulDiv(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    applyStimulus(2'b11, op, a, b, 16'h0, 5'd0, 5'd0, 5'd9, 32'h0);
    checkOutput({tag, "_bubble_rw"},   EX_MEM_regwrite, 0);
    checkOutput({tag, "_bubble_type"}, EX_MEM_instruc_type, 0);
    ID_EX_instruc_type = 2'b00;
    ID_EX_op           = 6'd0;
    n = 0;
    while (ex_stall_c && n < 40) begin
      n++;
      step();
    end
    checkOutput({tag, "_stall_cycles"}, n, 32);
  endtask

  task automatic checkHiLo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    applyStimulus(2'b11, 6'b010000, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd5, 32'h0);
    checkOutput({tag, "_mfhi"},      EX_MEM_ALUout, hi);
    checkOutput({tag, "_mfhi_dest"}, EX_MEM_dest, 5);
    checkOutput({tag, "_mfhi_rw"},   EX_MEM_regwrite, 1);
    applyStimulus(2'b11, 6'b010010, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd6, 32'h0);
    checkOutput({tag, "_mflo"},      EX_MEM_ALUout, lo);
    checkOutput({tag, "_mflo_dest"}, EX_MEM_dest, 6);
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    mem_stall_c = 1'b0;
    ID_EX_instruc_type = 2'b00;
    ID_EX_op = 6'd0; ID_EX_A = 32'd0; ID_EX_B = 32'd0; ID_EX_imm = 16'd0;
    ID_EX_rs = 5'd0; ID_EX_rt = 5'd0; ID_EX_rd = 5'd0; ID_EX_nextPC = 32'd0;
    step();
    step();
    checkZeroOutputs("reset");
    reset = 1'b0;

    applyStimulus(2'b11, 6'b100000, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd3, 32'h0);
    checkOutput("add_alu",  EX_MEM_ALUout, 12);
    checkOutput("add_dest", EX_MEM_dest, 3);
    checkOutput("add_rw",   EX_MEM_regwrite, 1);
    checkOutput("add_type", EX_MEM_instruc_type, 2'b11);
    checkOutput("add_b",    EX_MEM_B, 7);

    applyStimulus(2'b11, 6'b100010, 32'd5, 32'd7, 16'h0, 5'd1, 5'd2, 5'd4, 32'h0);
    checkOutput("sub_alu", EX_MEM_ALUout, 32'hFFFF_FFFE);
    applyStimulus(2'b11, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 16'h0, 5'd1, 5'd2, 5'd4, 32'h0);
    checkOutput("and_alu", EX_MEM_ALUout, 32'h0000_F000);
    applyStimulus(2'b11, 6'b100101, 32'h0000_F0F0, 32'h0000_FF00, 16'h0, 5'd1, 5'd2, 5'd4, 32'h0);
    checkOutput("or_alu", EX_MEM_ALUout, 32'h0000_FFF0);
    applyStimulus(2'b11, 6'b101010, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd1, 5'd2, 5'd4, 32'h0);
    checkOutput("slt_neg_lt", EX_MEM_ALUout, 1);
    applyStimulus(2'b11, 6'b101010, 32'd1, 32'hFFFF_FFFF, 16'h0, 5'd1, 5'd2, 5'd4, 32'h0);
    checkOutput("slt_pos_ge", EX_MEM_ALUout, 0);
    applyStimulus(2'b11, 6'b100000, 32'hFFFF_FFFF, 32'd2, 16'h0, 5'd1, 5'd2, 5'd4, 32'h0);
    checkOutput("add_wrap", EX_MEM_ALUout, 1);

    applyStimulus(2'b10, 6'b001000, 32'd10, 32'd0, 16'hFFFE, 5'd1, 5'd8, 5'd0, 32'h0);
    checkOutput("addi_alu",  EX_MEM_ALUout, 8);
    checkOutput("addi_dest", EX_MEM_dest, 8);
    checkOutput("addi_rw",   EX_MEM_regwrite, 1);
    applyStimulus(2'b10, 6'b101011, 32'h0000_1000, 32'hCAFE_0001, 16'h0010, 5'd1, 5'd9, 5'd0, 32'h0);
    checkOutput("sw_alu", EX_MEM_ALUout, 32'h0000_1010);
    checkOutput("sw_rw",  EX_MEM_regwrite, 0);
    checkOutput("sw_b",   EX_MEM_B, 32'hCAFE_0001);

    applyStimulus(2'b10, 6'b000100, 32'd9, 32'd9, 16'hFFFF, 5'd1, 5'd2, 5'd0, 32'h0000_0100);
    checkOutput("beq_taken",  EX_MEM_branch_taken, 1);
    checkOutput("beq_target", EX_MEM_target, 32'h0000_00FC);
    checkOutput("beq_rw",     EX_MEM_regwrite, 0);
    applyStimulus(2'b10, 6'b000100, 32'd9, 32'd8, 16'h0004, 5'd1, 5'd2, 5'd0, 32'h0000_0100);
    checkOutput("beq_not_taken", EX_MEM_branch_taken, 0);

    applyStimulus(2'b01, 6'b000010, 32'd0, 32'd0, 16'h0003, 5'd1, 5'd2, 5'd0, 32'hA000_0000);
    checkOutput("j_taken",  EX_MEM_branch_taken, 1);
    checkOutput("j_target", EX_MEM_target, 32'hA088_000C);
    checkOutput("j_rw",     EX_MEM_regwrite, 0);

    // LW arrives during a 3-cycle memory stall; the J result must hold until the stall drops.
    mem_stall_c = 1'b1;
    applyStimulus(2'b10, 6'b100011, 32'h0000_1000, 32'd0, 16'h0004, 5'd1, 5'd7, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_hold_tgt", EX_MEM_target, 32'hA088_000C);
      checkOutput("stall_hold_op",  EX_MEM_op, 6'b000010);
      if (i < 2) step();
    end
    mem_stall_c = 1'b0;
    step();
    checkOutput("lw_alu",  EX_MEM_ALUout, 32'h0000_1004);
    checkOutput("lw_dest", EX_MEM_dest, 7);
    checkOutput("lw_rw",   EX_MEM_regwrite, 1);

    applyStimulus(2'b00, 6'b000000, 32'd3, 32'd4, 16'h0, 5'd1, 5'd2, 5'd3, 32'h0);
    checkOutput("nop_alu", EX_MEM_ALUout, 0);
    checkOutput("nop_rw",  EX_MEM_regwrite, 0);
    applyStimulus(2'b11, 6'b111111, 32'd3, 32'd4, 16'h0, 5'd1, 5'd2, 5'd3, 32'h0);
    checkOutput("unlisted_rw", EX_MEM_regwrite, 0);
    checkOutput("unlisted_op", EX_MEM_op, 6'b111111);

`ifdef EX_MULDIV_EN
    runMulDiv("mult_big", 6'b011000, 32'h0001_0000, 32'h0001_0000);
    checkHiLo("mult_big", 32'd1, 32'd0);
    runMulDiv("mult_small", 6'b011000, 32'd7, 32'd6);
    checkHiLo("mult_small", 32'd0, 32'd42);
    runMulDiv("div_zero", 6'b011010, 32'd7, 32'd0);
    checkHiLo("div_zero", 32'd7, 32'hFFFF_FFFF);
    runMulDiv("div_100_7", 6'b011010, 32'd100, 32'd7);
    checkHiLo("div_100_7", 32'd2, 32'd14);

    // Reset in the middle of a DIV aborts it and clears HI/LO.
    applyStimulus(2'b11, 6'b011010, 32'd50, 32'd3, 16'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    ID_EX_instruc_type = 2'b00;
    ID_EX_op           = 6'd0;
    for (int i = 0; i < 10; i++) step();
    checkOutput("div_mid_stall", ex_stall_c, 1);
    reset = 1'b1;
    step();
    checkZeroOutputs("busy_reset");
    reset = 1'b0;
    checkHiLo("after_reset", 32'd0, 32'd0);
`else
    applyStimulus(2'b11, 6'b011000, 32'd7, 32'd6, 16'h0, 5'd0, 5'd0, 5'd9, 32'h0);
    checkOutput("mult_nop_alu",   EX_MEM_ALUout, 0);
    checkOutput("mult_nop_rw",    EX_MEM_regwrite, 0);
    checkOutput("mult_nop_type",  EX_MEM_instruc_type, 2'b11);
    checkOutput("mult_nop_stall", ex_stall_c, 0);
    applyStimulus(2'b11, 6'b010000, 32'd7, 32'd6, 16'h0, 5'd0, 5'd0, 5'd5, 32'h0);
    checkOutput("mfhi_alu",  EX_MEM_ALUout, 0);
    checkOutput("mfhi_rw",   EX_MEM_regwrite, 1);
    checkOutput("mfhi_dest", EX_MEM_dest, 5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: DATA_SIZE, 32, operand/result width; ADDRESS_SIZE, 32, PC width.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mem_stall_c  in  1  downstream memory stage stalled.
REQ-005 ID_EX_nextPC  in  ADDRESS_SIZE  PC+4 of the instruction.
REQ-006 ID_EX_A  in  DATA_SIZE  rs operand value.
REQ-007 ID_EX_B  in  DATA_SIZE  rt operand value.
REQ-008 ID_EX_imm, ID_EX_rs, ID_EX_rt, ID_EX_rd  in  16/5/5/5  instruction fields.
REQ-009 ID_EX_op  in  6  funct (R-type) or opcode (I/J-type).
REQ-010 ID_EX_instruc_type  in  2  11 R, 10 I, 01 J, 00 NOP.
REQ-011 EX_MEM_ALUout  out  DATA_SIZE  ALU result or memory address.
REQ-012 EX_MEM_B  out  DATA_SIZE  store data (rt value).
REQ-013 EX_MEM_dest  out  5  writeback register number.
REQ-014 EX_MEM_op, EX_MEM_instruc_type  out  6/2  forwarded op and type.
REQ-015 EX_MEM_regwrite  out  1  instruction writes the register file.
REQ-016 EX_MEM_branch_taken  out  1  redirect fetch to EX_MEM_target.
REQ-017 EX_MEM_target  out  ADDRESS_SIZE  branch/jump target.
REQ-018 ex_stall_c  out  1  execute stage busy; upstream holds.

Function
REQ-019 An instruction is accepted when state is IDLE and mem_stall_c is 0; EX_MEM_* registers update one cycle after acceptance.
REQ-020 R-type ops: ADD 100000 (A+B), SUB 100010 (A-B), AND 100100, OR 100101, SLT 101010 (signed A<B gives 1, else 0); dest=rd, regwrite=1; 32-bit wrap-around, no overflow trap.
REQ-021 I-type ops: ADDI 001000 (A+sext(imm), dest=rt, regwrite=1); LW 100011 and SW 101011 (ALUout=A+sext(imm); LW dest=rt, regwrite=1; SW regwrite=0).
REQ-022 BEQ 000100: branch_taken=1 iff A==B; target=nextPC+(sext(imm)<<2); regwrite=0.
REQ-023 J 000010 (type 01): branch_taken=1; target={nextPC[31:28], rs, rt, imm, 2'b00}; regwrite=0.
REQ-024 NOP and unlisted ops: regwrite=0, branch_taken=0, ALUout=0, type/op forwarded.
REQ-025 MULT 011000 / DIV 011010 (R-type, unsigned): on acceptance the FSM moves IDLE->BUSY, captures A and B, and the EX_MEM slot receives a bubble (type 00, regwrite 0).
REQ-026 BUSY: one shift-add (MULT) or restoring-subtract (DIV) iteration per cycle, 5-bit counter; after exactly 32 iterations HI/LO are written and the FSM returns to IDLE.
REQ-027 ex_stall_c=1 exactly while state is BUSY (32 cycles per MULT/DIV); EX_MEM outputs carry bubbles during BUSY.
REQ-028 MULT: {HI,LO}=A*B. DIV: LO=A/B, HI=A%B; if B=0: LO=32'hFFFFFFFF, HI=A, still 32 cycles.
REQ-029 MFHI 010000 / MFLO 010010: ALUout=HI/LO, dest=rd, regwrite=1.
REQ-030 mem_stall_c=1: all EX_MEM_* outputs hold; no new acceptance; a BUSY iteration continues, and completion during the stall returns the FSM to IDLE.
REQ-031 Reset asserted in BUSY aborts the operation; HI/LO are not updated.

Reset
REQ-032 On reset: all EX_MEM_* outputs = 0, state=IDLE, counter=0, HI=LO=0, ex_stall_c=0.

Configuration
REQ-033 With EX_MULDIV_EN defined: MULT/DIV/MFHI/MFLO behave as in REQ-025..REQ-029.
REQ-034 Without EX_MULDIV_EN: no FSM/HI/LO logic; MULT/DIV are treated as NOP; MFHI/MFLO write 0 to rd; ex_stall_c is tied to 0.

Verification
REQ-035 ADD, A=5, B=7, rd=3 -> next cycle ALUout=12, dest=3, regwrite=1.
REQ-036 BEQ, A=B=9, nextPC=0x100, imm=0xFFFF -> branch_taken=1, target=0xFC.
REQ-037 MULT, A=0x10000, B=0x10000, then MFHI -> ex_stall_c high for 32 cycles; MFHI ALUout=1; MFLO ALUout=0.
REQ-038 DIV, A=7, B=0 -> after 32 cycles HI=7, LO=0xFFFFFFFF.
REQ-039 LW issued while mem_stall_c=1 for 3 cycles -> EX_MEM outputs hold; LW result appears 1 cycle after the stall drops.
REQ-040 reset asserted at BUSY cycle 10 of a DIV -> next cycle all outputs 0, ex_stall_c=0, HI=LO=0.
